// File: rtl/sevenseg_scroller_if.sv
// Byte-wide valid/ready write port carrying ASCII message bytes into the
// seven-segment scroller. The master drives bytes; the scroller is the slave.
interface sevenseg_scroller_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/sevenseg_scroller.sv
// Message buffer and scrolling 4-character window feeding a 4-digit
// seven-segment driver. A message is loaded byte by byte, committed, and then
// shown through a window that steps circularly across message + blank gap.
module sevenseg_scroller #(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    sevenseg_scroller_if.slave             wr,
    input  logic                           scroll_en,
    output logic [7:0]                     display_0,
    output logic [7:0]                     display_1,
    output logic [7:0]                     display_2,
    output logic [7:0]                     display_3,
    output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
    output logic                           wrap
);

    localparam int LW = $clog2(MSG_DEPTH + 1);       // message length / write count
    localparam int AW = $clog2(MSG_DEPTH);           // buffer address
    localparam int PW = $clog2(MSG_DEPTH + GAP + 4); // window position and raw index
    localparam int CW = $clog2(TICK_DIV);            // prescaler

    localparam logic [LW-1:0] DEPTH_M1  = LW'(MSG_DEPTH - 1);
    localparam logic [LW-1:0] SHORT_LEN = LW'(4);
    localparam logic [PW-1:0] GAP_P     = PW'(GAP);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DASH  = 8'h2D;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_COMMIT,
        ST_SHOW
    } state_t;

    state_t          state_q, state_d;
    logic            wr_ready_q;
    logic [LW-1:0]   wcnt_q, wcnt_d;
    logic [LW-1:0]   msg_len_q, msg_len_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [CW-1:0]   presc_q, presc_d;
    logic            wrap_q, wrap_d;

    logic [7:0]      buf_q [MSG_DEPTH];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;

    logic            accept;
    logic [PW-1:0]   period_q;
    logic [PW-1:0]   period_d;
    logic [7:0]      disp_w [4];

    // Scroll period: short messages sit in a fixed 4-wide frame, long ones
    // are followed by GAP blanks before repeating.
    function automatic logic [PW-1:0] period_of(input logic [LW-1:0] len);
        if (len <= SHORT_LEN) begin
            return PW'(4);
        end
        return PW'(len) + GAP_P;
    endfunction

    assign accept   = wr.wr_valid & wr_ready_q;
    assign period_q = period_of(msg_len_q);
    assign period_d = period_of(msg_len_d);

    // Next-state logic: load/commit sequencing, message replacement and scrolling.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        msg_len_d = msg_len_q;
        pos_d     = pos_q;
        presc_d   = presc_q;
        wrap_d    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wcnt_d  = LW'(1);
                    state_d = wr.wr_last ? ST_COMMIT : ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = wcnt_q[AW-1:0];
                    wcnt_d  = wcnt_q + LW'(1);
                    // A full buffer commits on its own; further bytes start anew.
                    if (wr.wr_last || (wcnt_q == DEPTH_M1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end

            ST_COMMIT: begin
                msg_len_d = wcnt_q;
                pos_d     = '0;
                presc_d   = '0;
                wcnt_d    = '0;
                state_d   = ST_SHOW;
            end

            ST_SHOW: begin
                if (accept) begin
                    // A new byte always wins over a scroll tick in the same cycle.
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    wcnt_d    = LW'(1);
                    msg_len_d = '0;
                    state_d   = wr.wr_last ? ST_COMMIT : ST_LOAD;
                end else if ((msg_len_q > SHORT_LEN) && scroll_en) begin
                    if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        if (pos_q == (period_q - PW'(1))) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end else begin
                        presc_d = presc_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            wr_ready_q <= 1'b1;
            wcnt_q     <= '0;
            msg_len_q  <= '0;
            pos_q      <= '0;
            presc_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ready_q <= (state_d != ST_COMMIT);
            wcnt_q     <= wcnt_d;
            msg_len_q  <= msg_len_d;
            pos_q      <= pos_d;
            presc_q    <= presc_d;
            wrap_q     <= wrap_d;
        end
    end

    // Message storage; contents after reset are irrelevant, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_addr] <= wr.wr_data;
        end
    end

    // One window slot per digit, computed from next-state values so the
    // displays move on the same edge as the position and state.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [PW-1:0] raw_idx;
            logic [PW-1:0] win_idx;
            logic          in_msg;
            logic [7:0]    win_char;
            logic [7:0]    disp_d;
            logic [7:0]    disp_q;

            // pos < P and gi < 4 <= P, so a single subtraction wraps the index.
            assign raw_idx  = pos_d + PW'(gi);
            assign win_idx  = (raw_idx >= period_d) ? (raw_idx - period_d) : raw_idx;
            assign in_msg   = (win_idx < PW'(msg_len_d));
            assign win_char = in_msg ? buf_q[win_idx[AW-1:0]] : CH_SPACE;

            // Digit content: blanks when empty, dashes while loading, window when shown.
            always_comb begin
                disp_d = CH_SPACE;
                case (state_d)
                    ST_SHOW:   disp_d = win_char;
                    ST_LOAD:   disp_d = CH_DASH;
                    ST_COMMIT: disp_d = CH_DASH;
                    default:   disp_d = CH_SPACE;
                endcase
            end

            // Registered digit output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    disp_q <= CH_SPACE;
                end else begin
                    disp_q <= disp_d;
                end
            end

            assign disp_w[gi] = disp_q;
        end
    endgenerate

    assign wr.wr_ready = wr_ready_q;
    assign display_0   = disp_w[0];
    assign display_1   = disp_w[1];
    assign display_2   = disp_w[2];
    assign display_3   = disp_w[3];
    assign msg_len     = msg_len_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_sevenseg_scroller.sv
// Randomized bench for sevenseg_scroller. The reference model tracks the
// committed message as a queue and the number of enabled SHOW cycles since
// commit; the window is derived from those with plain arithmetic.
module tb_sevenseg_scroller;

    localparam int DEPTH = 16;
    localparam int TDIV  = 4;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scroll_en = 1'b0;
    logic [7:0] display_0, display_1, display_2, display_3;
    logic [4:0] msg_len;
    logic       wrap;

    sevenseg_scroller_if wif ();

    sevenseg_scroller #(
        .MSG_DEPTH (DEPTH),
        .TICK_DIV  (TDIV),
        .GAP       (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wif.slave),
        .scroll_en (scroll_en),
        .display_0 (display_0),
        .display_1 (display_1),
        .display_2 (display_2),
        .display_3 (display_3),
        .msg_len   (msg_len),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_msg [$];   // committed message (empty while none)
    logic [7:0] m_ld  [$];   // bytes of the message being loaded
    bit         m_commit;    // commit cycle in progress
    bit         m_show;      // a committed message is on display
    int         m_ecnt;      // enabled scroll cycles since commit
    bit         m_wrap;

    logic [7:0] tx_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_msg = {};
        m_ld = {};
        m_commit = 0;
        m_show = 0;
        m_ecnt = 0;
        m_wrap = 0;
    endtask

    function automatic logic [31:0] exp_disp();
        logic [31:0] r;
        int L, P, pos, i;
        if (!m_show)
            return (m_ld.size() > 0 || m_commit) ? 32'h2D2D2D2D : 32'h20202020;
        L   = m_msg.size();
        P   = (L <= 4) ? 4 : L + GAP;
        pos = (L <= 4) ? 0 : (m_ecnt / TDIV) % P;
        r   = '0;
        for (int k = 0; k < 4; k++) begin
            i = (pos + k) % P;
            r = {r[23:0], (i < L) ? m_msg[i] : 8'h20};
        end
        return r;
    endfunction

    function automatic logic [31:0] disp_now();
        return {display_0, display_1, display_2, display_3};
    endfunction

    // One clock cycle: drive inputs, advance the model, compare all outputs.
    task automatic cyc(input bit v, input logic [7:0] d, input bit last, input bit se,
                       output bit acc);
        int P;
        wif.wr_valid = v;
        wif.wr_data  = d;
        wif.wr_last  = last;
        scroll_en    = se;
        acc = v && !m_commit;
        @(posedge clk);
        #1;
        m_wrap = 0;
        if (m_commit) begin
            m_msg = m_ld;
            m_ld = {};
            m_commit = 0;
            m_show = 1;
            m_ecnt = 0;
        end else if (acc) begin
            m_show = 0;
            m_msg = {};
            m_ld.push_back(d);
            if (last || m_ld.size() == DEPTH) m_commit = 1;
        end else if (m_show && se && m_msg.size() > 4) begin
            m_ecnt++;
            P = m_msg.size() + GAP;
            m_wrap = (m_ecnt % TDIV == 0) && ((m_ecnt / TDIV) % P == 0);
        end
        chk("display", disp_now(), exp_disp());
        chk("msg_len", 32'(msg_len), 32'(m_msg.size()));
        chk("wr_ready", 32'(wif.wr_ready), 32'(!m_commit));
        chk("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic idle(input int n, input int seprob);
        bit acc;
        for (int c = 0; c < n; c++)
            cyc(1'b0, 8'($urandom), 1'b0, $urandom_range(99) < seprob, acc);
    endtask

    // Push tx_q through the write port with random valid gaps.
    task automatic send(input bit with_last, input int vprob, input int seprob);
        bit acc, v;
        int tries;
        for (int n = 0; n < tx_q.size(); n++) begin
            tries = 0;
            acc = 0;
            while (!acc && tries < 100) begin
                v = ($urandom_range(99) < vprob);
                cyc(v, tx_q[n], with_last && (n == tx_q.size() - 1),
                    $urandom_range(99) < seprob, acc);
                tries++;
            end
            chk("send_accept", 32'(acc), 32'(1));
        end
        wif.wr_valid = 1'b0;
        $display("tx: %0d bytes last=%0b msg_len=%0d", tx_q.size(), with_last, msg_len);
    endtask

    task automatic fill_random(input int len);
        tx_q = {};
        for (int n = 0; n < len; n++) tx_q.push_back(8'($urandom_range(8'h7E, 8'h21)));
    endtask

    initial begin
        bit wl;
        wif.wr_valid = 1'b0;
        wif.wr_data  = 8'h00;
        wif.wr_last  = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_display", disp_now(), 32'h20202020);
        chk("rst_msg_len", 32'(msg_len), 32'(0));
        chk("rst_wr_ready", 32'(wif.wr_ready), 32'(1));
        chk("rst_wrap", 32'(wrap), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Short message stays static and never wraps
        tx_q = {8'h48, 8'h45};
        send(1'b1, 100, 100);
        idle(1, 100);
        chk("short_window", disp_now(), 32'h48452020);
        idle(3 * TDIV, 100);
        chk("short_hold", disp_now(), 32'h48452020);

        // Scrolling "HELLo" (L=5, P=9), with a 10-cycle freeze mid-run
        tx_q = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h6F};
        send(1'b1, 100, 100);
        idle(1, 100);
        chk("hello_first", disp_now(), 32'h48454C4C);
        idle(TDIV, 100);
        chk("hello_step1", disp_now(), 32'h454C4C6F);
        idle(TDIV, 100);
        chk("hello_step2", disp_now(), 32'h4C4C6F20);
        idle(10, 0);
        idle(9 * TDIV, 100);

        // Overflow: 17 bytes, forced commit after 16, byte 17 starts a new load
        fill_random(17);
        send(1'b0, 100, 100);
        chk("ovf_loading", disp_now(), 32'h2D2D2D2D);
        tx_q = {8'h41};
        send(1'b1, 100, 100);
        idle(6, 100);

        // Replace during SHOW
        fill_random(8);
        send(1'b1, 100, 100);
        idle(21, 100);
        tx_q = {8'h30, 8'h37};
        send(1'b1, 100, 100);
        idle(1, 100);
        chk("replace_window", disp_now(), 32'h30372020);
        idle(5, 100);

        // Random messages, including back-to-back ones that stall on commit
        for (int it = 0; it < 40; it++) begin
            fill_random($urandom_range(20, 1));
            wl = (tx_q.size() < DEPTH) ? 1'b1 : $urandom_range(1);
            send(wl, $urandom_range(100, 50), 85);
            if ($urandom_range(3) != 0) idle($urandom_range(60), 85);
        end

        // Asynchronous reset while scrolling
        fill_random(10);
        send(1'b1, 100, 100);
        idle(23, 100);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_display", disp_now(), 32'h20202020);
        chk("async_rst_msg_len", 32'(msg_len), 32'(0));
        chk("async_rst_wr_ready", 32'(wif.wr_ready), 32'(1));
        chk("async_rst_wrap", 32'(wrap), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Still functional after reset
        for (int it = 0; it < 4; it++) begin
            fill_random($urandom_range(12, 1));
            send(1'b1, 80, 90);
            idle($urandom_range(40, 5), 90);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
